// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR addresses, op encodings and update helper
package csr_pkg;

    // Writable machine counter and scratch CSRs
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    // User-level read-only shadows of the counters
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

    // mcountinhibit bit positions that are actually stored
    localparam int INH_CY = 0;
    localparam int INH_IR = 2;

    typedef enum logic [2:0] {
        OP_RW  = 3'b001,
        OP_RS  = 3'b010,
        OP_RC  = 3'b011,
        OP_RWI = 3'b101,
        OP_RSI = 3'b110,
        OP_RCI = 3'b111
    } csr_op_e;

    // Register and immediate forms share the same update; only the source differs
    function automatic logic [31:0] csr_apply(input logic [2:0] op,
                                              input logic [31:0] old,
                                              input logic [31:0] src);
        logic [31:0] res;
        case (op)
            OP_RW, OP_RWI: res = src;
            OP_RS, OP_RSI: res = old | src;
            OP_RC, OP_RCI: res = old & ~src;
            default:       res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit counter with per-half write that overrides increment
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [63:0] cnt
);

    // A half-write leaves the other half untouched and drops that cycle's increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (we_lo) begin
            cnt[31:0] <= wdata;
        end else if (we_hi) begin
            cnt[63:32] <= wdata;
        end else if (inc) begin
            cnt <= cnt + 64'd1;
        end
    end

endmodule

// File: rtl/csr_counter_unit.sv
// rtl/csr_counter_unit.sv - machine counter CSR write side with legality check
module csr_counter_unit
    import csr_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int CNT_W       = 64,
    parameter int HAS_INHIBIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csr_en,
    input  logic             stall,
    input  logic [2:0]       func3,
    input  logic [11:0]      csr_addr,
    input  logic [4:0]       src_idx,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_o,
    output logic [CNT_W-1:0] instret_o,
    output logic [XLEN-1:0]  mscratch_o,
    output logic [XLEN-1:0]  mcountinhibit_o,
    output logic             illegal_o
);

    localparam logic [XLEN-1:0] INH_MASK = (XLEN'(1) << INH_CY) | (XLEN'(1) << INH_IR);

    logic [63:0]     cyc_cnt;
    logic [63:0]     ir_cnt;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic            is_rw;
    logic            is_ro;
    logic            wr_form;
    logic            go;
    logic            wr_en;
    logic            illegal_d;

    // Address decode, operand select and legality of the EX-stage CSR access
    always_comb begin
        is_rw   = 1'b0;
        is_ro   = 1'b0;
        old_val = '0;
        case (csr_addr)
            CSR_MCYCLE:        begin is_rw = 1'b1; old_val = cyc_cnt[31:0];  end
            CSR_MCYCLEH:       begin is_rw = 1'b1; old_val = cyc_cnt[63:32]; end
            CSR_MINSTRET:      begin is_rw = 1'b1; old_val = ir_cnt[31:0];   end
            CSR_MINSTRETH:     begin is_rw = 1'b1; old_val = ir_cnt[63:32];  end
            CSR_MSCRATCH:      begin is_rw = 1'b1; old_val = mscratch_o;     end
            CSR_MCOUNTINHIBIT: begin is_rw = 1'b1; old_val = mcountinhibit_o; end
            CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: is_ro = 1'b1;
            default: ;
        endcase
        src       = func3[2] ? {{(XLEN-5){1'b0}}, src_idx} : rs1_data;
        // Set/clear with a zero source (x0 or zimm 0) is a pure read
        wr_form   = (func3[1:0] == 2'b01) || ((func3[1:0] != 2'b00) && (src_idx != 5'd0));
        new_val   = csr_apply(func3, old_val, src);
        go        = csr_en && !stall;
        illegal_d = go && (!(is_rw || is_ro) || (is_ro && wr_form));
        wr_en     = go && is_rw && wr_form;
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (!mcountinhibit_o[INH_CY]),
        .we_lo (wr_en && (csr_addr == CSR_MCYCLE)),
        .we_hi (wr_en && (csr_addr == CSR_MCYCLEH)),
        .wdata (new_val),
        .cnt   (cyc_cnt)
    );

    // Retire is a WB event, so it counts regardless of the EX stall
    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire && !mcountinhibit_o[INH_IR]),
        .we_lo (wr_en && (csr_addr == CSR_MINSTRET)),
        .we_hi (wr_en && (csr_addr == CSR_MINSTRETH)),
        .wdata (new_val),
        .cnt   (ir_cnt)
    );

    // Scratch/inhibit registers and the one-cycle illegal pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mscratch_o      <= '0;
            mcountinhibit_o <= '0;
            illegal_o       <= 1'b0;
        end else begin
            illegal_o <= illegal_d;
            if (wr_en && (csr_addr == CSR_MSCRATCH)) begin
                mscratch_o <= new_val;
            end
            if (wr_en && (csr_addr == CSR_MCOUNTINHIBIT) && (HAS_INHIBIT != 0)) begin
                mcountinhibit_o <= new_val & INH_MASK;
            end
        end
    end

    assign cycle_o   = cyc_cnt;
    assign instret_o = ir_cnt;

endmodule

// File: tb/tb_csr_counter_unit.sv
// tb/tb_csr_counter_unit.sv - directed and random checks against a counter CSR model
module tb_csr_counter_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_en;
    logic        stall;
    logic [2:0]  func3;
    logic [11:0] csr_addr;
    logic [4:0]  src_idx;
    logic [31:0] rs1_data;
    logic        retire;
    logic [63:0] cycle_o;
    logic [63:0] instret_o;
    logic [31:0] mscratch_o;
    logic [31:0] mcountinhibit_o;
    logic        illegal_o;

    int errors = 0;
    int checks = 0;

    // Reference state: architectural counter values as plain integers
    logic [63:0] m_cyc;
    logic [63:0] m_ir;
    logic [31:0] m_scr;
    logic [31:0] m_inh;
    logic        m_ill;

    csr_counter_unit #(.XLEN(32), .CNT_W(64), .HAS_INHIBIT(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .csr_en          (csr_en),
        .stall           (stall),
        .func3           (func3),
        .csr_addr        (csr_addr),
        .src_idx         (src_idx),
        .rs1_data        (rs1_data),
        .retire          (retire),
        .cycle_o         (cycle_o),
        .instret_o       (instret_o),
        .mscratch_o      (mscratch_o),
        .mcountinhibit_o (mcountinhibit_o),
        .illegal_o       (illegal_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".cycle"},    cycle_o,                  m_cyc);
        chk({tag, ".instret"},  instret_o,                m_ir);
        chk({tag, ".mscratch"}, {32'h0, mscratch_o},      {32'h0, m_scr});
        chk({tag, ".inhibit"},  {32'h0, mcountinhibit_o}, {32'h0, m_inh});
        chk({tag, ".illegal"},  {63'h0, illegal_o},       {63'h0, m_ill});
    endtask

    task automatic model_reset();
        m_cyc = '0; m_ir = '0; m_scr = '0; m_inh = '0; m_ill = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model by the architectural rules, compare
    task automatic step(input string tag, input logic en, input logic st, input logic [2:0] f3,
                        input logic [11:0] a, input logic [4:0] idx, input logic [31:0] r,
                        input logic ret);
        logic [31:0] src, old, nv;
        logic        writable, readonly, wants_write, go, we;
        logic [63:0] n_cyc, n_ir;
        csr_en = en; stall = st; func3 = f3; csr_addr = a; src_idx = idx;
        rs1_data = r; retire = ret;

        src = f3[2] ? {27'h0, idx} : r;
        writable = 1'b1; readonly = 1'b0; old = 32'h0;
        case (a)
            12'hB00: old = m_cyc[31:0];
            12'hB80: old = m_cyc[63:32];
            12'hB02: old = m_ir[31:0];
            12'hB82: old = m_ir[63:32];
            12'h340: old = m_scr;
            12'h320: old = m_inh;
            12'hC00, 12'hC80, 12'hC02, 12'hC82: begin writable = 1'b0; readonly = 1'b1; end
            default: writable = 1'b0;
        endcase
        if (f3[1:0] == 2'b01)      nv = src;
        else if (f3[1:0] == 2'b10) nv = old | src;
        else                       nv = old & ~src;
        wants_write = (f3[1:0] == 2'b01) || (idx != 5'd0);
        go = en && !st;
        we = go && writable && wants_write;

        n_cyc = m_cyc;
        if (we && a == 12'hB00)      n_cyc = {m_cyc[63:32], nv};
        else if (we && a == 12'hB80) n_cyc = {nv, m_cyc[31:0]};
        else if (!m_inh[0])          n_cyc = m_cyc + 64'd1;
        n_ir = m_ir;
        if (we && a == 12'hB02)      n_ir = {m_ir[63:32], nv};
        else if (we && a == 12'hB82) n_ir = {nv, m_ir[31:0]};
        else if (ret && !m_inh[2])   n_ir = m_ir + 64'd1;

        @(posedge clk);
        #1;
        m_cyc = n_cyc;
        m_ir  = n_ir;
        if (we && a == 12'h340) m_scr = nv;
        if (we && a == 12'h320) m_inh = nv & 32'h5;
        m_ill = go && (!(writable || readonly) || (readonly && wants_write));
        chk_all(tag);
    endtask

    task automatic idle(input string tag, input logic ret);
        step(tag, 1'b0, 1'b0, 3'b001, 12'h000, 5'd0, 32'h0, ret);
    endtask

    logic [11:0] addr_tbl [12] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h340, 12'h320,
                                   12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7FF, 12'h341};
    logic [2:0]  op_tbl [6]    = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    initial begin
        rst = 1'b0; csr_en = 1'b0; stall = 1'b0; func3 = 3'b001; csr_addr = '0;
        src_idx = '0; rs1_data = '0; retire = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        rst = 1'b1;

        // Idle after reset release
        for (int i = 0; i < 10; i++) idle("idle", 1'b0);
        chk("idle10.cycle", cycle_o, 64'd10);
        chk("idle10.instret", instret_o, 64'd0);

        // Carry from lo into hi
        step("wr_cyc_lo", 1, 0, 3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFE, 0);
        step("wr_cyc_hi", 1, 0, 3'b001, 12'hB80, 5'd1, 32'h0, 0);
        chk("carry0", cycle_o, 64'h0_FFFF_FFFE);
        idle("carry", 0);
        chk("carry1", cycle_o, 64'h0_FFFF_FFFF);
        idle("carry", 0);
        chk("carry2", cycle_o, 64'h1_0000_0000);

        // minstret write drops a coincident retire
        step("wr_ir", 1, 0, 3'b001, 12'hB02, 5'd1, 32'h100, 1);
        chk("ir_wr", instret_o, 64'h100);
        idle("ir_ret", 1);
        chk("ir_ret", instret_o, 64'h101);

        // Inhibit both, then release only mcycle
        step("inh_set", 1, 0, 3'b110, 12'h320, 5'd5, 32'h0, 1);
        chk("inh_val", {32'h0, mcountinhibit_o}, 64'h5);
        for (int i = 0; i < 3; i++) idle("inh_both", 1'b1);
        step("inh_clr", 1, 0, 3'b111, 12'h320, 5'd1, 32'h0, 1);
        chk("inh_val2", {32'h0, mcountinhibit_o}, 64'h4);
        for (int i = 0; i < 3; i++) idle("inh_ir", 1'b1);

        // Illegal accesses and their stalled / read-only-safe variants
        step("ro_write", 1, 0, 3'b001, 12'hC00, 5'd3, 32'h1234, 0);
        chk("ro_pulse", {63'h0, illegal_o}, 64'h1);
        idle("ro_after", 0);
        chk("ro_one_cycle", {63'h0, illegal_o}, 64'h0);
        step("ro_read", 1, 0, 3'b010, 12'hC00, 5'd0, 32'hFFFF, 0);
        chk("ro_read_quiet", {63'h0, illegal_o}, 64'h0);
        step("bad_addr", 1, 0, 3'b010, 12'h7FF, 5'd0, 32'h0, 0);
        chk("bad_addr_pulse", {63'h0, illegal_o}, 64'h1);
        step("st_ro", 1, 1, 3'b001, 12'hC00, 5'd3, 32'h1234, 0);
        step("st_bad", 1, 1, 3'b010, 12'h7FF, 5'd0, 32'h0, 0);
        step("st_wr", 1, 1, 3'b001, 12'hB00, 5'd3, 32'h0, 1);

        // mscratch write then clear
        step("scr_rw", 1, 0, 3'b001, 12'h340, 5'd2, 32'hA5A5_A5A5, 0);
        step("scr_rc", 1, 0, 3'b011, 12'h340, 5'd2, 32'h0000_FFFF, 0);
        chk("scr_val", {32'h0, mscratch_o}, 64'hA5A5_0000);

        // Asynchronous reset mid-sequence
        idle("pre_rst", 1);
        rst = 1'b0;
        #2;
        model_reset();
        chk_all("async_rst");
        #1 rst = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 1) == 0), ($urandom_range(0, 3) == 0),
                 op_tbl[$urandom_range(0, 5)], addr_tbl[$urandom_range(0, 11)],
                 ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom),
                 $urandom, ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
